// File: rtl/cam_lookup_arb.sv
// cam_lookup_arb: round-robin arbiter sharing one cam_lut_sm lookup port among NUM_REQ requesters.
// Define CAM_LOOKUP_ARB_STATS_EN to build the stat_hits/stat_misses counters (tied to 0 otherwise).
module cam_lookup_arb #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned CMP_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH      = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*CMP_WIDTH-1:0]   req_cmp_data,
    input  logic [NUM_REQ*CMP_WIDTH-1:0]   req_cmp_dmask,
    output logic [NUM_REQ-1:0]             req_gnt,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic                           resp_hit,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           lookup_req,
    output logic [CMP_WIDTH-1:0]           lookup_cmp_data,
    output logic [CMP_WIDTH-1:0]           lookup_cmp_dmask,
    input  logic                           lookup_ack,
    input  logic                           lookup_hit,
    input  logic [DATA_WIDTH-1:0]          lookup_data,
    output logic                           err_orphan_ack,
    output logic [31:0]                    stat_hits,
    output logic [31:0]                    stat_misses
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;

    logic [CMP_WIDTH-1:0] data_arr [NUM_REQ];
    logic [CMP_WIDTH-1:0] mask_arr [NUM_REQ];

    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     cand;
    logic                 found;
    logic                 pop;
    logic                 transfer;
    logic                 can_grant;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_cmp_data[g*CMP_WIDTH +: CMP_WIDTH];
        assign mask_arr[g] = req_cmp_dmask[g*CMP_WIDTH +: CMP_WIDTH];
    end

    // A pop in the same cycle frees a slot, so a full FIFO may still grant.
    assign pop       = lookup_ack && (count != '0);
    assign can_grant = (state != ISSUE) && ((count != FULL_COUNT) || pop);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        if (can_grant) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                cand = IDX_W'((32'(rr_ptr) + j) % NUM_REQ);
                if (!found && req_valid[cand]) begin
                    found        = 1'b1;
                    gnt[cand]    = 1'b1;
                    gnt_idx      = cand;
                end
            end
        end
    end

    assign req_gnt  = gnt;
    assign transfer = |(req_valid & gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            lookup_req       <= 1'b0;
            lookup_cmp_data  <= '0;
            lookup_cmp_dmask <= '0;
            resp_valid       <= '0;
            resp_hit         <= 1'b0;
            resp_data        <= '0;
            err_orphan_ack   <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: state <= transfer ? ISSUE : IDLE;
                ISSUE:      state <= HOLD;
                default:    state <= IDLE;
            endcase

            lookup_req <= transfer;

            if (transfer) begin
                lookup_cmp_data  <= data_arr[gnt_idx];
                lookup_cmp_dmask <= mask_arr[gnt_idx];
                wr_ptr           <= wr_ptr + 1'b1;
                if (gnt_idx == IDX_W'(NUM_REQ - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= gnt_idx + 1'b1;
            end

            resp_valid <= '0;
            if (pop) begin
                resp_valid[tag_mem[rd_ptr]] <= 1'b1;
                resp_hit                    <= lookup_hit;
                resp_data                   <= lookup_data;
                rd_ptr                      <= rd_ptr + 1'b1;
            end

            case ({transfer, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (lookup_ack && (count == '0))
                err_orphan_ack <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (transfer)
            tag_mem[wr_ptr] <= gnt_idx;
    end

`ifdef CAM_LOOKUP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (pop) begin
            if (lookup_hit)
                stat_hits <= stat_hits + 32'd1;
            else
                stat_misses <= stat_misses + 32'd1;
        end
    end
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule
